// File: rtl/cam_pkg.sv
// cam_pkg: shared constants, FSM encoding and pixel conversion for the
// OV7670 capture path (QQVGA RGB444 frame buffer writer).
package cam_pkg;

  localparam int CAM_SCREEN_X = 160;                        // pixels per line
  localparam int CAM_SCREEN_Y = 120;                        // lines per frame
  localparam int IMA_SIZE     = CAM_SCREEN_X * CAM_SCREEN_Y;
  localparam int AW           = 15;                         // ceil(log2(IMA_SIZE))
  localparam int DW           = 12;                         // RGB444

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    FRAME_IDLE = 2'd1,
    CAPTURE    = 2'd2
  } cam_state_e;

  // Keep the top 4 bits of each RGB565 channel.
  // hi = R4..R0 G5..G3, lo = G2..G0 B4..B0.
  function automatic logic [DW-1:0] rgb565_to_rgb444(input logic [7:0] hi,
                                                     input logic [7:0] lo);
    return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
  endfunction

endpackage

// File: rtl/cam_capture_rgb444.sv
// cam_capture_rgb444: OV7670 byte stream -> RGB444 frame-buffer writes.
// Ports:
//   clk, rst              capture clock (CAM_pclk), synchronous active-high reset
//   CAM_px_data[7:0]      camera byte
//   CAM_href, CAM_vsync   line-valid / vertical sync from the sensor
//   DP_RAM_regW           write strobe, one cycle per stored pixel
//   DP_RAM_addr_in[AW-1:0]  linear address row*CAM_SCREEN_X + col
//   DP_RAM_data_in[DW-1:0]  {R[3:0],G[3:0],B[3:0]}
//   frame_done            one-cycle pulse when a frame ends
//   line_err              sticky per frame: a line had the wrong byte count
module cam_capture_rgb444
  import cam_pkg::*;
#(
  parameter int AW           = cam_pkg::AW,
  parameter int DW           = cam_pkg::DW,
  parameter int CAM_SCREEN_X = cam_pkg::CAM_SCREEN_X,
  parameter int CAM_SCREEN_Y = cam_pkg::CAM_SCREEN_Y
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    CAM_px_data,
  input  logic          CAM_href,
  input  logic          CAM_vsync,
  output logic          DP_RAM_regW,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [DW-1:0] DP_RAM_data_in,
  output logic          frame_done,
  output logic          line_err
);

  localparam int CW = $clog2(CAM_SCREEN_X + 1);
  localparam int RW = $clog2(CAM_SCREEN_Y + 1);
  localparam logic [CW-1:0] COL_MAX   = CW'(CAM_SCREEN_X);
  localparam logic [RW-1:0] ROW_MAX   = RW'(CAM_SCREEN_Y);
  localparam logic [AW-1:0] LINE_STEP = AW'(CAM_SCREEN_X);

  cam_state_e    state_q, state_d;
  logic          vsync_d_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] row_base_q, row_base_d;   // row*CAM_SCREEN_X without a multiplier
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          phase_q, phase_d;         // 1: high byte held, waiting for low byte
  logic          long_q, long_d;           // line delivered more than CAM_SCREEN_X pixels
  logic [7:0]    hi_q, hi_d;
  logic          regw_q, regw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          frame_done_q, frame_done_d;
  logic          line_err_q, line_err_d;
  logic          start_of_frame;

  assign start_of_frame = vsync_d_q & ~CAM_vsync;

  // Next-state and registered-output computation for the capture FSM.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    row_base_d   = row_base_q;
    row_d        = row_q;
    col_d        = col_q;
    phase_d      = phase_q;
    long_d       = long_q;
    hi_d         = hi_q;
    regw_d       = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    frame_done_d = 1'b0;
    line_err_d   = line_err_q;

    case (state_q)
      WAIT_FRAME: begin
        if (start_of_frame) begin
          state_d    = FRAME_IDLE;
          wr_ptr_d   = '0;
          row_base_d = '0;
          row_d      = '0;
          phase_d    = 1'b0;
          line_err_d = 1'b0;
        end else begin
          state_d = WAIT_FRAME;
        end
      end

      FRAME_IDLE: begin
        if (CAM_vsync) begin
          state_d      = WAIT_FRAME;
          frame_done_d = 1'b1;
        end else if (CAM_href) begin
          state_d = CAPTURE;
          col_d   = '0;
          long_d  = 1'b0;
          hi_d    = CAM_px_data;
          phase_d = 1'b1;
        end else begin
          state_d = FRAME_IDLE;
        end
      end

      CAPTURE: begin
        if (CAM_vsync) begin
          // Sync wins over href: abandon the partial line.
          state_d      = WAIT_FRAME;
          frame_done_d = 1'b1;
          phase_d      = 1'b0;
          if ((col_q != '0) || phase_q) begin
            line_err_d = 1'b1;
          end else begin
            line_err_d = line_err_q;
          end
        end else if (CAM_href) begin
          if (!phase_q) begin
            hi_d    = CAM_px_data;
            phase_d = 1'b1;
          end else begin
            if ((col_q < COL_MAX) && (row_q < ROW_MAX)) begin
              regw_d   = 1'b1;
              addr_d   = wr_ptr_q;
              data_d   = rgb565_to_rgb444(hi_q, CAM_px_data);
              wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
              wr_ptr_d = wr_ptr_q;
            end
            // col saturates, so remember separately that the line overran.
            if (col_q < COL_MAX) begin
              col_d = col_q + CW'(1);
            end else begin
              long_d = 1'b1;
            end
            phase_d = 1'b0;
          end
        end else begin
          state_d = FRAME_IDLE;
          phase_d = 1'b0;
          if ((col_q != COL_MAX) || phase_q || long_q) begin
            line_err_d = 1'b1;
          end else begin
            line_err_d = line_err_q;
          end
          // Realign to the next row base so a short/long line cannot skew later rows.
          if (row_q < ROW_MAX) begin
            row_d      = row_q + RW'(1);
            row_base_d = row_base_q + LINE_STEP;
            wr_ptr_d   = row_base_q + LINE_STEP;
          end else begin
            row_d = row_q;
          end
        end
      end

      default: begin
        state_d = WAIT_FRAME;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_FRAME;
      vsync_d_q    <= 1'b0;
      wr_ptr_q     <= '0;
      row_base_q   <= '0;
      row_q        <= '0;
      col_q        <= '0;
      phase_q      <= 1'b0;
      long_q       <= 1'b0;
      hi_q         <= 8'd0;
      regw_q       <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_d_q    <= CAM_vsync;
      wr_ptr_q     <= wr_ptr_d;
      row_base_q   <= row_base_d;
      row_q        <= row_d;
      col_q        <= col_d;
      phase_q      <= phase_d;
      long_q       <= long_d;
      hi_q         <= hi_d;
      regw_q       <= regw_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      line_err_q   <= line_err_d;
    end
  end

  assign DP_RAM_regW    = regw_q;
  assign DP_RAM_addr_in = addr_q;
  assign DP_RAM_data_in = data_q;
  assign frame_done     = frame_done_q;
  assign line_err       = line_err_q;

endmodule

// File: tb/tb_cam_capture_rgb444.sv
// Self-checking bench for cam_capture_rgb444: table of frame scenarios plus
// hand-written sequences (full frame, mid-line vsync, mid-frame reset).
module tb_cam_capture_rgb444;

  localparam int X  = 160;
  localparam int Y  = 120;
  localparam int AW = 15;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    CAM_px_data;
  logic          CAM_href;
  logic          CAM_vsync;
  logic          DP_RAM_regW;
  logic [AW-1:0] DP_RAM_addr_in;
  logic [DW-1:0] DP_RAM_data_in;
  logic          frame_done;
  logic          line_err;

  always #5 clk = ~clk;

  cam_capture_rgb444 dut (
    .clk            (clk),
    .rst            (rst),
    .CAM_px_data    (CAM_px_data),
    .CAM_href       (CAM_href),
    .CAM_vsync      (CAM_vsync),
    .DP_RAM_regW    (DP_RAM_regW),
    .DP_RAM_addr_in (DP_RAM_addr_in),
    .DP_RAM_data_in (DP_RAM_data_in),
    .frame_done     (frame_done),
    .line_err       (line_err)
  );

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int n0; int n1; int mode; int exp_writes; bit exp_err; } vec_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  vec_t vecs[6];
  int   vectors = 0;
  int   miscompares = 0;
  int   wr_count = 0;
  int   fd_count = 0;
  int   last_addr = -1;
  int   model_row = 0;
  bit   pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference conversion via channel arithmetic: widen to RGB565, drop LSBs.
  function automatic int exp_px(input int hi, input int lo);
    int r5, g6, b5;
    r5 = hi >> 3;
    g6 = ((hi & 7) << 3) | (lo >> 5);
    b5 = lo & 31;
    return ((r5 >> 1) << 8) | ((g6 >> 2) << 4) | (b5 >> 1);
  endfunction

  // mode 0: random, 1: pure red, 2: pure green
  function automatic logic [7:0] pick_byte(input int mode, input int b);
    if (mode == 1) return (b % 2 == 0) ? 8'hF8 : 8'h00;
    if (mode == 2) return (b % 2 == 0) ? 8'h07 : 8'hE0;
    return 8'($urandom_range(0, 255));
  endfunction

  // Write monitor: every strobe must match the next expected write.
  always @(negedge clk) begin
    if (frame_done) fd_count++;
    if (DP_RAM_regW) begin
      wr_count++;
      last_addr = int'(DP_RAM_addr_in);
      chk("addr_below_sentinel", 32'(int'(DP_RAM_addr_in) < X * Y), 32'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", 32'(DP_RAM_addr_in), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(DP_RAM_addr_in), 32'(mon_e.addr));
        chk("wr_data", 32'(DP_RAM_data_in), 32'(mon_e.data));
      end
    end
  end

  // endmode 0: href drops, 1: vsync rises with href still high, 2: leave line open
  task automatic send_line(input int n, input int mode, input int endmode);
    int hi = 0;
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      chk("regw_timing", 32'(DP_RAM_regW), 32'(pend));
      CAM_px_data = pick_byte(mode, b);
      CAM_href    = 1'b1;
      if (b % 2 == 0) hi = int'(CAM_px_data);
      pend = (b % 2 == 1) && (b / 2 < X) && (model_row < Y);
      if (pend) exp_q.push_back('{model_row * X + b / 2, exp_px(hi, int'(CAM_px_data))});
    end
    if (endmode == 2) return;
    @(negedge clk);
    chk("regw_timing", 32'(DP_RAM_regW), 32'(pend));
    pend = 1'b0;
    if (endmode == 1) CAM_vsync = 1'b1;
    else CAM_href = 1'b0;
    model_row++;
    repeat (3) begin
      @(negedge clk);
      chk("regw_idle", 32'(DP_RAM_regW), 32'd0);
    end
    CAM_href = 1'b0;
  endtask

  task automatic start_frame();
    @(negedge clk);
    CAM_href  = 1'b0;
    CAM_vsync = 1'b1;
    repeat (3) @(negedge clk);
    CAM_vsync = 1'b0;
    repeat (2) @(negedge clk);
    chk("line_err_cleared", 32'(line_err), 32'd0);
    model_row = 0;
    wr_count  = 0;
    fd_count  = 0;
    pend      = 1'b0;
    exp_q.delete();
  endtask

  task automatic end_frame(input int exp_writes, input bit exp_err);
    @(negedge clk);
    CAM_href  = 1'b0;
    CAM_vsync = 1'b1;
    repeat (4) @(negedge clk);
    chk("frame_done_pulses", 32'(fd_count), 32'd1);
    chk("write_count", 32'(wr_count), 32'(exp_writes));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("line_err", 32'(line_err), 32'(exp_err));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_regW"}, 32'(DP_RAM_regW), 32'd0);
    chk({tag, "_addr"}, 32'(DP_RAM_addr_in), 32'd0);
    chk({tag, "_data"}, 32'(DP_RAM_data_in), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_line_err"}, 32'(line_err), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{320, 0,   1, 160, 1'b0};  // one red line
    vecs[1] = '{100, 320, 0, 210, 1'b1};  // short line then full line at base 160
    vecs[2] = '{330, 320, 0, 320, 1'b1};  // long line clipped to 160 pixels
    vecs[3] = '{319, 320, 0, 319, 1'b1};  // odd byte count
    vecs[4] = '{1,   2,   0, 1,   1'b1};  // degenerate lines
    vecs[5] = '{320, 320, 0, 320, 1'b0};  // two clean random lines

    rst = 1'b1; CAM_href = 1'b0; CAM_vsync = 1'b0; CAM_px_data = 8'd0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // href activity before any VSYNC edge must be ignored
    for (int b = 0; b < 10; b++) begin
      @(negedge clk);
      chk("no_write_before_frame", 32'(DP_RAM_regW), 32'd0);
      CAM_href = 1'b1;
      CAM_px_data = 8'($urandom_range(0, 255));
    end
    CAM_href = 1'b0;

    for (int i = 0; i < 6; i++) begin
      start_frame();
      send_line(vecs[i].n0, vecs[i].mode, 0);
      if (vecs[i].n1 > 0) send_line(vecs[i].n1, vecs[i].mode, 0);
      end_frame(vecs[i].exp_writes, vecs[i].exp_err);
    end

    // Full green frame plus one surplus line that must be dropped
    start_frame();
    for (int r = 0; r < Y + 1; r++) send_line(2 * X, 2, 0);
    end_frame(X * Y, 1'b0);
    chk("last_addr", 32'(last_addr), 32'(X * Y - 1));

    // VSYNC mid-line after 50 pixels, then a clean frame restarting at 0
    start_frame();
    send_line(100, 0, 1);
    end_frame(50, 1'b1);
    start_frame();
    send_line(2 * X, 0, 0);
    end_frame(X, 1'b0);

    // Reset pulse mid-line: nothing written until the next VSYNC fall
    start_frame();
    send_line(40, 0, 2);
    @(negedge clk);
    chk("regw_timing", 32'(DP_RAM_regW), 32'(pend));
    pend = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("midreset");
    repeat (60) begin
      @(negedge clk);
      chk("no_write_after_reset", 32'(DP_RAM_regW), 32'd0);
      CAM_px_data = 8'($urandom_range(0, 255));
    end
    CAM_href = 1'b0;
    start_frame();
    send_line(2 * X, 0, 0);
    end_frame(X, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
